// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_pkg
//  Description : Shared types and constants for the MUX select-scan sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    // Width of the per-code settle counter; SETTLE_CYCLES is limited to 255.
    localparam int CNT_W = 8;

    // Sequencer state encoding.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Number of select codes driven for a given select-bus width.
    function automatic int n_in(input int sel_bits);
        return 1 << sel_bits;
    endfunction

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_ctrl_if
//  Description : Handshake and MUX-side signals of the select-scan sequencer.
//                slave  = the sequencer itself
//                master = controller plus the MUX under characterisation
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_ctrl_if #(
    parameter int N_SEL_BITS = 1
);
    import mux_scan_pkg::*;

    localparam int N_IN = n_in(N_SEL_BITS);

    logic                  start;
    logic [N_SEL_BITS-1:0] sel;
    logic                  mux_y;
    logic                  busy;
    logic                  done;
    logic [N_IN-1:0]       result;
    logic                  result_valid;

    modport slave (
        input  start,
        input  mux_y,
        output sel,
        output busy,
        output done,
        output result,
        output result_valid
    );

    modport master (
        output start,
        output mux_y,
        input  sel,
        input  busy,
        input  done,
        input  result,
        input  result_valid
    );

endinterface : mux_scan_ctrl_if
`default_nettype wire

// File: rtl/mux_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_settle_timer
//  Description : Per-code hold counter. expire is high on the last cycle of
//                each SETTLE_CYCLES+1 window; the counter wraps to zero on
//                that cycle so the next code starts a fresh window.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // With SETTLE_CYCLES=0 the count stays at zero and every cycle expires.
    assign expire = (r_cnt == c_LAST);

    // Hold counter: cleared on a new scan, counts only while scanning.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= expire ? '0 : (r_cnt + c_ONE);
        end
    end

endmodule : mux_settle_timer
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_ctrl
//  Description : Steps a downstream MUX select through codes 0..N_IN-1,
//                samples Y at the end of each code's hold window and builds
//                the captured truth vector. start/busy/done handshake; the
//                result is held until the next accepted start.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int N_SEL_BITS    = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus
);

    localparam int                    N_IN       = n_in(N_SEL_BITS);
    localparam logic [N_SEL_BITS-1:0] c_SEL_LAST = N_SEL_BITS'(N_IN - 1);
    localparam logic [N_SEL_BITS-1:0] c_SEL_ONE  = N_SEL_BITS'(1);

    state_t                r_state,  w_state_nxt;
    logic [N_SEL_BITS-1:0] r_sel,    w_sel_nxt;
    logic                  r_busy,   w_busy_nxt;
    logic                  r_done,   w_done_nxt;
    logic [N_IN-1:0]       r_result, w_result_nxt;
    logic                  r_valid,  w_valid_nxt;

    logic                  w_tmr_clr;
    logic                  w_tmr_en;
    logic                  w_expire;

    mux_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_tmr_clr),
        .en     (w_tmr_en),
        .expire (w_expire)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_valid_nxt  = r_valid;
        w_tmr_clr    = 1'b0;
        w_tmr_en     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Also reached in the done cycle, so a start there is honoured.
                if (bus.start) begin
                    w_state_nxt  = ST_SCAN;
                    w_busy_nxt   = 1'b1;
                    w_sel_nxt    = '0;
                    w_result_nxt = '0;
                    w_valid_nxt  = 1'b0;
                    w_tmr_clr    = 1'b1;
                end
            end
            ST_SCAN: begin
                // start is deliberately not looked at here: no queuing.
                w_tmr_en = 1'b1;
                if (w_expire) begin
                    w_result_nxt[r_sel] = bus.mux_y;
                    if (r_sel == c_SEL_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_sel_nxt   = '0;
                    end else begin
                        w_sel_nxt = r_sel + c_SEL_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    assign bus.sel          = r_sel;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;

endmodule : mux_scan_ctrl
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_ctrl
//  Description : Directed self-checking bench for mux_scan_ctrl. Four
//                instances cover the parameter sets of interest; each drives
//                a modelled downstream MUX whose inputs the bench sets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // a: 2:1, settle 1   b: 4:1, settle 0   c: 2:1, settle 3   d: 2:1, settle 0
    mux_scan_ctrl_if #(.N_SEL_BITS(1)) bus_a ();
    mux_scan_ctrl_if #(.N_SEL_BITS(2)) bus_b ();
    mux_scan_ctrl_if #(.N_SEL_BITS(1)) bus_c ();
    mux_scan_ctrl_if #(.N_SEL_BITS(1)) bus_d ();

    logic [1:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_c;
    logic [1:0] in_d;

    // Downstream MUX models: Y = I[sel]
    assign bus_a.mux_y = in_a[bus_a.sel];
    assign bus_b.mux_y = in_b[bus_b.sel];
    assign bus_c.mux_y = in_c[bus_c.sel];
    assign bus_d.mux_y = in_d[bus_d.sel];

    mux_scan_ctrl #(.N_SEL_BITS(1), .SETTLE_CYCLES(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mux_scan_ctrl #(.N_SEL_BITS(2), .SETTLE_CYCLES(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    mux_scan_ctrl #(.N_SEL_BITS(1), .SETTLE_CYCLES(3)) u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));
    mux_scan_ctrl #(.N_SEL_BITS(1), .SETTLE_CYCLES(0)) u_dut_d (.clk(clk), .rst(rst), .bus(bus_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int busy_cnt;
        int done_cnt;
        bit pulsed;
        logic [1:0] pats [4];

        rst = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        bus_d.start = 1'b0;
        in_a = 2'b10;
        in_b = 4'b1011;
        in_c = 2'b01;
        in_d = 2'b10;
        tick();
        tick();
        rst = 1'b0;

        // ---- reset state
        check("rst_sel",   32'(bus_a.sel), 32'd0);
        check("rst_busy",  32'(bus_a.busy), 32'd0);
        check("rst_done",  32'(bus_a.done), 32'd0);
        check("rst_res",   32'(bus_a.result), 32'd0);
        check("rst_valid", 32'(bus_a.result_valid), 32'd0);
        check("rst_b_res", 32'(bus_b.result), 32'd0);

        // ---- 1: AND-from-MUX with A=1 (I1=0, I2=1), settle 1
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_busy", 32'(bus_a.busy), 32'd1);
            check("t1_sel",  32'(bus_a.sel), (i < 2) ? 32'd0 : 32'd1);
            check("t1_done_low", 32'(bus_a.done), 32'd0);
            tick();
        end
        check("t1_done",  32'(bus_a.done), 32'd1);
        check("t1_busy_end", 32'(bus_a.busy), 32'd0);
        check("t1_res",   32'(bus_a.result), 32'h2);
        check("t1_valid", 32'(bus_a.result_valid), 32'd1);
        check("t1_sel_end", 32'(bus_a.sel), 32'd0);
        tick();
        check("t1_done_pulse", 32'(bus_a.done), 32'd0);
        check("t1_valid_hold", 32'(bus_a.result_valid), 32'd1);
        check("t1_res_hold", 32'(bus_a.result), 32'h2);

        // ---- 2: A=0 -> 00, then I1=1, I2=0 -> 01
        in_a = 2'b00;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("t2_valid_drop", 32'(bus_a.result_valid), 32'd0);
        check("t2_res_clr", 32'(bus_a.result), 32'd0);
        repeat (4) tick();
        check("t2a_done", 32'(bus_a.done), 32'd1);
        check("t2a_res",  32'(bus_a.result), 32'h0);
        tick();
        in_a = 2'b01;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("t2b_valid_drop", 32'(bus_a.result_valid), 32'd0);
        repeat (4) tick();
        check("t2b_done",  32'(bus_a.done), 32'd1);
        check("t2b_res",   32'(bus_a.result), 32'h1);
        check("t2b_valid", 32'(bus_a.result_valid), 32'd1);

        // ---- 3: 4:1 mux, settle 0, inputs I3..I0 = 1,0,1,1
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_sel",  32'(bus_b.sel), 32'(i));
            check("t3_busy", 32'(bus_b.busy), 32'd1);
            tick();
        end
        check("t3_done", 32'(bus_b.done), 32'd1);
        check("t3_busy_end", 32'(bus_b.busy), 32'd0);
        check("t3_res",  32'(bus_b.result), 32'hB);
        tick();

        // ---- 4: start re-pulsed mid-scan (settle 3) is ignored
        bus_c.start = 1'b1;
        tick();
        bus_c.start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        pulsed = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus_c.busy) busy_cnt++;
            if (bus_c.done) done_cnt++;
            if (bus_c.sel == 1'b1 && !pulsed) begin
                bus_c.start = 1'b1;
                pulsed = 1'b1;
            end else begin
                bus_c.start = 1'b0;
            end
            tick();
        end
        bus_c.start = 1'b0;
        check("t4_pulsed", 32'(pulsed), 32'd1);
        check("t4_busy_cycles", 32'(busy_cnt), 32'd8);
        check("t4_done_count", 32'(done_cnt), 32'd1);
        check("t4_res", 32'(bus_c.result), 32'h1);

        // ---- 5: reset while sel=1 mid-scan
        bus_c.start = 1'b1;
        tick();
        bus_c.start = 1'b0;
        n = 0;
        while (bus_c.sel != 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t5_reach_sel1", 32'(bus_c.sel), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_sel",   32'(bus_c.sel), 32'd0);
        check("t5_busy",  32'(bus_c.busy), 32'd0);
        check("t5_done",  32'(bus_c.done), 32'd0);
        check("t5_res",   32'(bus_c.result), 32'd0);
        check("t5_valid", 32'(bus_c.result_valid), 32'd0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (bus_c.busy) busy_cnt++;
            if (bus_c.done) done_cnt++;
        end
        check("t5_no_done", 32'(done_cnt), 32'd0);
        check("t5_no_busy", 32'(busy_cnt), 32'd0);

        // ---- 6: start held high, settle 0 -> done every 3 cycles
        pats[0] = 2'b10;
        pats[1] = 2'b01;
        pats[2] = 2'b11;
        pats[3] = 2'b00;
        in_d = pats[0];
        bus_d.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!bus_d.done && n < 10);
            check("t6_done_seen", 32'(bus_d.done), 32'd1);
            check("t6_period", 32'(n), 32'd3);
            check("t6_res", 32'(bus_d.result), 32'(pats[k]));
            check("t6_valid", 32'(bus_d.result_valid), 32'd1);
            if (k < 3) in_d = pats[k + 1];
        end
        tick();
        check("t6_restart_busy", 32'(bus_d.busy), 32'd1);
        check("t6_restart_valid", 32'(bus_d.result_valid), 32'd0);
        bus_d.start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_scan_ctrl
`default_nettype wire
